// File: rtl/tick_slot_scheduler.sv
// Tick-paced round-robin scheduler: a prescaler derives a slow tick, and each
// winner holds the shared resource for at most SLOT_TICKS ticks.
module tick_slot_scheduler #(
  parameter int NREQ       = 4,
  parameter int PRESCALE   = 5,
  parameter int SLOT_TICKS = 3
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic            tick,
  output logic [NREQ-1:0] grant,
  output logic            active,
  output logic            timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(SLOT_TICKS) + 1;

  localparam logic [CW-1:0] PS_MAX   = CW'(PRESCALE - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT_TICKS - 1);
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t        state;
  logic [CW-1:0] pcnt;
  logic [SW-1:0] slot_cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] pick;
  logic          found;
  logic [PW:0]   scan;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pcnt <= '0;
    end else if (enable) begin
      pcnt <= (pcnt == PS_MAX) ? '0 : pcnt + 1'b1;
    end
  end

  assign tick   = enable && (pcnt == PS_MAX);
  assign active = |grant;

  // Search upward from the priority pointer, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan = {1'b0, ptr} + (PW+1)'(i);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!found && req[scan[PW-1:0]]) begin
        found = 1'b1;
        pick  = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      timeout  <= 1'b0;
      slot_cnt <= '0;
      ptr      <= '0;
      win      <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick && found) begin
            win      <= pick;
            grant    <= NREQ'(1) << pick;
            slot_cnt <= '0;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Release by done/dropped req takes precedence over slot expiry.
          if (done[win] || !req[win]) begin
            grant <= '0;
            state <= S_RELEASE;
          end else if (tick) begin
            if (slot_cnt == SLOT_MAX) begin
              grant   <= '0;
              timeout <= 1'b1;
              state   <= S_RELEASE;
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end
        end
        S_RELEASE: begin
          ptr   <= (win == LAST_IDX) ? '0 : win + 1'b1;
          state <= S_IDLE;
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_slot_scheduler.sv
// Self-checking bench for tick_slot_scheduler: per-scenario stimulus and
// expectation tables, expectations queued at drive time and checked at negedge.
module tb_tick_slot_scheduler;

  logic       clk_in;
  logic       reset;
  logic       enable;
  logic [3:0] req;
  logic [3:0] done;
  logic       tick;
  logic [3:0] grant;
  logic       active;
  logic       timeout;

  tick_slot_scheduler #(
    .NREQ      (4),
    .PRESCALE  (5),
    .SLOT_TICKS(3)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (enable),
    .req    (req),
    .done   (done),
    .tick   (tick),
    .grant  (grant),
    .active (active),
    .timeout(timeout)
  );

  typedef struct {
    int         cyc;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] done;
  } stim_t;

  typedef struct {
    int         cyc;
    logic       tick;
    logic [3:0] grant;
    logic       to;
  } chk_t;

  typedef struct {
    string      scn;
    int         cyc;
    logic       tick;
    logic [3:0] grant;
    logic       to;
  } exp_t;

  stim_t st[$];
  chk_t  ck[$];
  exp_t  exp_q[$];
  string cur_scn;
  int    checks   = 0;
  int    failures = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic void add_st(input int c, input logic r, input logic e,
                                 input logic [3:0] rq, input logic [3:0] dn);
    stim_t s;
    s.cyc = c; s.rst = r; s.en = e; s.req = rq; s.done = dn;
    st.push_back(s);
  endfunction

  function automatic void add_ck(input int c, input logic t, input logic [3:0] g, input logic to);
    chk_t k;
    k.cyc = c; k.tick = t; k.grant = g; k.to = to;
    ck.push_back(k);
  endfunction

  // Cycle 0 is the first cycle with reset low; inputs are applied #1 after each edge.
  task automatic run_scn(input string nm, input int ncyc);
    exp_t e;
    cur_scn = nm;
    reset = 1'b1; enable = 1'b1; req = '0; done = '0;
    @(posedge clk_in); #1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk_in); #1;
      end else begin
        reset = 1'b0;
      end
      foreach (st[i]) begin
        if (st[i].cyc == c) begin
          reset = st[i].rst; enable = st[i].en; req = st[i].req; done = st[i].done;
        end
      end
      foreach (ck[i]) begin
        if (ck[i].cyc == c) begin
          e.scn = nm; e.cyc = c; e.tick = ck[i].tick; e.grant = ck[i].grant; e.to = ck[i].to;
          exp_q.push_back(e);
        end
      end
    end
    @(negedge clk_in); #1;
    st.delete();
    ck.delete();
  endtask

  always @(negedge clk_in) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (tick !== e.tick || grant !== e.grant || timeout !== e.to || active !== (|e.grant)) begin
        failures++;
        $display("FAIL %s cyc=%0d tick/grant/active/timeout got %b/%b/%b/%b exp %b/%b/%b/%b",
                 e.scn, e.cyc, tick, grant, active, timeout, e.tick, e.grant, |e.grant, e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Prescaler only: ticks at 4, 9, 14; nothing granted.
    add_st(0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 16; c++)
      add_ck(c, (c == 4 || c == 9 || c == 14), 4'b0000, 1'b0);
    run_scn("prescaler", 16);

    // Slot timeout: three counted ticks 9/14/19, RELEASE at 20, re-grant at 25.
    add_st(0, 1'b0, 1'b1, 4'b0001, 4'b0000);
    add_ck(4,  1'b1, 4'b0000, 1'b0);
    add_ck(5,  1'b0, 4'b0001, 1'b0);
    add_ck(9,  1'b1, 4'b0001, 1'b0);
    add_ck(14, 1'b1, 4'b0001, 1'b0);
    add_ck(19, 1'b1, 4'b0001, 1'b0);
    add_ck(20, 1'b0, 4'b0000, 1'b1);
    add_ck(21, 1'b0, 4'b0000, 1'b0);
    add_ck(24, 1'b1, 4'b0000, 1'b0);
    add_ck(25, 1'b0, 4'b0001, 1'b0);
    run_scn("slot_timeout", 27);

    // Round robin with done two cycles after each grant.
    add_st(0,  1'b0, 1'b1, 4'b1111, 4'b0000);
    add_st(7,  1'b0, 1'b1, 4'b1111, 4'b0001);
    add_st(8,  1'b0, 1'b1, 4'b1111, 4'b0000);
    add_st(12, 1'b0, 1'b1, 4'b1111, 4'b0010);
    add_st(13, 1'b0, 1'b1, 4'b1111, 4'b0000);
    add_st(17, 1'b0, 1'b1, 4'b1111, 4'b0100);
    add_st(18, 1'b0, 1'b1, 4'b1111, 4'b0000);
    add_st(22, 1'b0, 1'b1, 4'b1111, 4'b1000);
    add_st(23, 1'b0, 1'b1, 4'b1111, 4'b0000);
    add_ck(5,  1'b0, 4'b0001, 1'b0);
    add_ck(8,  1'b0, 4'b0000, 1'b0);
    add_ck(10, 1'b0, 4'b0010, 1'b0);
    add_ck(13, 1'b0, 4'b0000, 1'b0);
    add_ck(15, 1'b0, 4'b0100, 1'b0);
    add_ck(18, 1'b0, 4'b0000, 1'b0);
    add_ck(20, 1'b0, 4'b1000, 1'b0);
    add_ck(23, 1'b0, 4'b0000, 1'b0);
    add_ck(25, 1'b0, 4'b0001, 1'b0);
    run_scn("round_robin", 27);

    // Done coincides with expiring tick; stray done[2] ignored.
    add_st(0,  1'b0, 1'b1, 4'b0001, 4'b0000);
    add_st(11, 1'b0, 1'b1, 4'b0001, 4'b0100);
    add_st(12, 1'b0, 1'b1, 4'b0001, 4'b0000);
    add_st(19, 1'b0, 1'b1, 4'b0001, 4'b0001);
    add_st(20, 1'b0, 1'b1, 4'b0001, 4'b0000);
    add_ck(12, 1'b0, 4'b0001, 1'b0);
    add_ck(19, 1'b1, 4'b0001, 1'b0);
    add_ck(20, 1'b0, 4'b0000, 1'b0);
    add_ck(21, 1'b0, 4'b0000, 1'b0);
    add_ck(25, 1'b0, 4'b0001, 1'b0);
    run_scn("done_vs_expiry", 27);

    // Reset while 0100 is granted: prescaler restarts, pointer back to 0.
    add_st(0,  1'b0, 1'b1, 4'b1111, 4'b0000);
    add_st(7,  1'b0, 1'b1, 4'b1111, 4'b0001);
    add_st(8,  1'b0, 1'b1, 4'b1111, 4'b0000);
    add_st(12, 1'b0, 1'b1, 4'b1111, 4'b0010);
    add_st(13, 1'b0, 1'b1, 4'b1111, 4'b0000);
    add_st(16, 1'b1, 1'b1, 4'b1111, 4'b0000);
    add_st(17, 1'b0, 1'b1, 4'b1111, 4'b0000);
    add_ck(15, 1'b0, 4'b0100, 1'b0);
    add_ck(16, 1'b0, 4'b0100, 1'b0);
    add_ck(17, 1'b0, 4'b0000, 1'b0);
    add_ck(19, 1'b0, 4'b0000, 1'b0);
    add_ck(21, 1'b1, 4'b0000, 1'b0);
    add_ck(22, 1'b0, 4'b0001, 1'b0);
    run_scn("reset_mid_grant", 25);

    // Enable low for 12 cycles mid-grant freezes the slot; expiry moves to tick 31.
    add_st(0,  1'b0, 1'b1, 4'b0001, 4'b0000);
    add_st(10, 1'b0, 1'b0, 4'b0001, 4'b0000);
    add_st(22, 1'b0, 1'b1, 4'b0001, 4'b0000);
    add_ck(9,  1'b1, 4'b0001, 1'b0);
    add_ck(10, 1'b0, 4'b0001, 1'b0);
    add_ck(14, 1'b0, 4'b0001, 1'b0);
    add_ck(19, 1'b0, 4'b0001, 1'b0);
    add_ck(20, 1'b0, 4'b0001, 1'b0);
    add_ck(21, 1'b0, 4'b0001, 1'b0);
    add_ck(22, 1'b0, 4'b0001, 1'b0);
    add_ck(26, 1'b1, 4'b0001, 1'b0);
    add_ck(31, 1'b1, 4'b0001, 1'b0);
    add_ck(32, 1'b0, 4'b0000, 1'b1);
    run_scn("enable_low", 34);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got %0d pending expectations, exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
